// File: rtl/uart_tx_wb_if.sv
// Wishbone request/response bundle for the uart_tx_wb register port.
interface uart_tx_wb_if;
  logic        CYC_I;
  logic        STB_I;
  logic        WR_I;
  logic [2:0]  ADR_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        ACK_O;

  modport master (output CYC_I, STB_I, WR_I, ADR_I, DAT_I, input DAT_O, ACK_O);
  modport slave  (input CYC_I, STB_I, WR_I, ADR_I, DAT_I, output DAT_O, ACK_O);
endinterface

// File: rtl/uart_tx_wb.sv
// Wishbone-mapped 8N1/8N2 UART transmitter with TX FIFO and watermark interrupt.
module uart_tx_wb #(
  parameter int unsigned CLOCK_FREQ_HZ = 100000000,
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned FIFO_DEPTH    = 8
) (
  input  logic         CLK_I,
  input  logic         RST_I,
  uart_tx_wb_if.slave  bus,
  output logic         txd,
  output logic         irq
);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0]   DIV_RST  = 16'(CLOCK_FREQ_HZ / BAUD_RATE - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic          txen, nstop, ie_txwm;
  logic [2:0]    txcnt;
  logic [15:0]   div;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic [15:0]   cnt;
  logic [2:0]    bidx;
  logic [7:0]    shreg;
  logic          stop2;

  logic        accept, wr, full, empty, push, pop, bit_end, frame_end, below_wm;
  logic [31:0] rdata;
  logic        unused_dat;

  assign unused_dat = &{1'b0, bus.DAT_I[31:19]};

  always_comb begin
    accept    = bus.CYC_I & bus.STB_I & ~bus.ACK_O;
    wr        = accept & bus.WR_I;
    full      = (count == CNT_FULL);
    empty     = (count == '0);
    below_wm  = 32'(count) < 32'(txcnt);
    push      = wr && (bus.ADR_I == 3'b000) && !full;
    bit_end   = (cnt == '0);
    // Frame ends at the close of the last stop bit; nstop is sampled at the first stop boundary.
    frame_end = (state == STOP) && bit_end && (stop2 || !nstop);
    pop       = txen && !empty && ((state == IDLE) || frame_end);
    rdata     = '0;
    case (bus.ADR_I)
      3'b000:  rdata[31]    = full;
      3'b010:  rdata        = {13'b0, txcnt, 14'b0, nstop, txen};
      3'b100:  rdata[0]     = ie_txwm;
      3'b101:  rdata[0]     = below_wm;
      3'b110:  rdata[15:0]  = div;
      default: rdata        = '0;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (push) mem[wptr] <= bus.DAT_I[7:0];
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      bus.ACK_O <= 1'b0;
      bus.DAT_O <= '0;
      txen      <= 1'b0;
      nstop     <= 1'b0;
      txcnt     <= '0;
      ie_txwm   <= 1'b0;
      div       <= DIV_RST;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      irq       <= 1'b0;
    end else begin
      bus.ACK_O <= accept;
      bus.DAT_O <= (accept && !bus.WR_I) ? rdata : '0;
      if (wr) begin
        case (bus.ADR_I)
          3'b010: begin
            txen  <= bus.DAT_I[0];
            nstop <= bus.DAT_I[1];
            txcnt <= bus.DAT_I[18:16];
          end
          3'b100:  ie_txwm <= bus.DAT_I[0];
          3'b110:  div     <= bus.DAT_I[15:0];
          default: ;
        endcase
      end
      if (push) wptr <= (wptr == PTR_LAST) ? '0 : wptr + PW'(1);
      if (pop)  rptr <= (rptr == PTR_LAST) ? '0 : rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      irq <= ie_txwm & below_wm;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state <= IDLE;
      txd   <= 1'b1;
      cnt   <= '0;
      bidx  <= '0;
      shreg <= '0;
      stop2 <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state <= START;
            txd   <= 1'b0;
            cnt   <= div;
            shreg <= mem[rptr];
          end
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            txd   <= shreg[0];
            cnt   <= div;
            bidx  <= '0;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= div;
            if (bidx == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
              stop2 <= 1'b0;
            end else begin
              bidx  <= bidx + 3'd1;
              shreg <= shreg >> 1;
              txd   <= shreg[1];
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            // Chaining straight into START keeps back-to-back frames gap-free.
            if (frame_end) begin
              if (pop) begin
                state <= START;
                txd   <= 1'b0;
                cnt   <= div;
                shreg <= mem[rptr];
              end else begin
                state <= IDLE;
              end
            end else begin
              stop2 <= 1'b1;
              cnt   <= div;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
